// File: rtl/ro_meas_pkg.sv
// Shared definitions for the ring-oscillator measurement sequencer.
// The state codes are visible on the seq_state port, so they are fixed.
package ro_meas_pkg;

  localparam int DEFAULT_CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_COUNT  = 3'd3,
    ST_REPORT = 3'd4,
    ST_HOLD   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/ro_meas_timer.sv
// Loadable down-counter that times the settle and count phases.
// Load has priority over decrement, and the counter saturates at zero.
module ro_meas_timer
  import ro_meas_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/ro_meas_seq.sv
// Ring-oscillator measurement sequencer: select, clear, settle, count, report.
// Sweep mode walks every channel back-to-back before parking in HOLD.
module ro_meas_seq
  import ro_meas_pkg::*;
#(
  parameter int CNT_W  = DEFAULT_CNT_W,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sweep,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [CNT_W-1:0]  cfg_settle,
  input  logic [CNT_W-1:0]  cfg_window,
  output logic [NUM_CH-1:0] ro_en,
  output logic              counterrst,
  output logic              counteren,
  output logic              result_valid,
  output logic [CH_W-1:0]   result_ch,
  output logic              busy,
  output logic              done,
  output logic [2:0]        seq_state
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  seq_state_e       state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0] settle_l, window_l;
  logic             sweep_l;
  logic [CH_W-1:0]  ch_sel_l;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  // A phase of N cycles loads N-1; zero length is stretched to one cycle.
  function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  function automatic logic [CH_W-1:0] clamp_ch(input logic [CH_W-1:0] c);
    return (int'(c) >= NUM_CH) ? LAST_CH : c;
  endfunction

  ro_meas_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      settle_l <= '0;
      window_l <= '0;
      sweep_l  <= 1'b0;
      ch_sel_l <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      // Configuration tracks the inputs only while idle and not yet started.
      if (state_q == ST_IDLE && !start) begin
        settle_l <= cfg_settle;
        window_l <= cfg_window;
        sweep_l  <= sweep;
        ch_sel_l <= ch_sel;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          ch_d    = sweep_l ? '0 : clamp_ch(ch_sel_l);
        end
      end
      ST_CLEAR: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = phase_load(settle_l);
        end
      end
      ST_SETTLE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d  = ST_COUNT;
          tmr_load = 1'b1;
          tmr_val  = phase_load(window_l);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d = ST_REPORT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_REPORT: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (sweep_l && (ch_q != LAST_CH)) begin
          state_d = ST_CLEAR;
          ch_d    = ch_q + CH_W'(1);
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    counterrst   = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
    counteren    = (state_q == ST_COUNT);
    result_valid = (state_q == ST_REPORT);
    busy         = (state_q != ST_IDLE) && (state_q != ST_HOLD);
    done         = (state_q == ST_HOLD);
    result_ch    = ch_q;
    seq_state    = state_q;
    for (int i = 0; i < NUM_CH; i++) begin
      ro_en[i] = ((state_q == ST_CLEAR) || (state_q == ST_SETTLE) ||
                  (state_q == ST_COUNT)) && (int'(ch_q) == i);
    end
  end

endmodule
